// File: rtl/alu_pkg.sv
// Shared ALU opcode map and command-driver FSM states.
// Used by the command driver and by the sequencer's decode.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_MUL    = 5'd2;
    localparam logic [4:0] OP_DIV    = 5'd3;
    localparam logic [4:0] OP_MOD    = 5'd4;
    localparam logic [4:0] OP_RSUB   = 5'd5;
    localparam logic [4:0] OP_RDIV   = 5'd6;
    localparam logic [4:0] OP_RMOD   = 5'd7;
    localparam logic [4:0] OP_AND    = 5'd8;
    localparam logic [4:0] OP_OR     = 5'd9;
    localparam logic [4:0] OP_XOR    = 5'd10;
    localparam logic [4:0] OP_NOT_A  = 5'd11;
    localparam logic [4:0] OP_NOT_B  = 5'd12;
    localparam logic [4:0] OP_SLL    = 5'd13;
    localparam logic [4:0] OP_SRL    = 5'd14;
    localparam logic [4:0] OP_SRA    = 5'd15;
    localparam logic [4:0] OP_EQ     = 5'd16;
    localparam logic [4:0] OP_LT     = 5'd17;
    localparam logic [4:0] OP_LTU    = 5'd18;
    localparam logic [4:0] OP_PASS_A = 5'd19;
    localparam logic [4:0] OP_PASS_B = 5'd20;
    localparam logic [4:0] OP_NEG_A  = 5'd21;
    localparam logic [4:0] OP_INC_A  = 5'd22;
    localparam logic [4:0] OP_INC_B  = 5'd23;

    localparam logic [4:0] OP_LAST   = 5'd23;
    localparam logic [4:0] OP_IDLE   = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_check.sv
// Combinational legality screen: unknown opcodes and zero divisors (b for DIV/MOD, a for RDIV/RMOD).
// Zero latency, no flow control.
module alu_op_check import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             illegal
);

    always_comb begin
        illegal = 1'b0;
        if (opcode > OP_LAST) begin
            illegal = 1'b1;
        end else if ((opcode == OP_DIV || opcode == OP_MOD) && b == '0) begin
            illegal = 1'b1;
        end else if ((opcode == OP_RDIV || opcode == OP_RMOD) && a == '0) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Screens one command at a time, drives the ALU for SETTLE_CYCLES, returns the captured result.
// Legal: response SETTLE_CYCLES+1 cycles after accept, illegal: next cycle; rsp_ready low stalls RESP and cmd_ready.
module alu_cmd_driver import alu_pkg::*; #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [4:0]       alu_opcode,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] done_count
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [SC_W-1:0] settle_cnt;
    logic            illegal;
    logic            accept;

    alu_op_check #(.WIDTH(WIDTH)) u_op_check (
        .opcode  (cmd_opcode),
        .a       (cmd_a),
        .b       (cmd_b),
        .illegal (illegal)
    );

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = illegal ? RESP : ISSUE;
            ISSUE:   if (settle_cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Leaving ISSUE or RESP parks the ALU on OP_IDLE so every issue is a visible opcode edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_opcode <= OP_IDLE;
            alu_en     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                        end else begin
                            alu_in1    <= cmd_a;
                            alu_in2    <= cmd_b;
                            alu_opcode <= cmd_opcode;
                            alu_en     <= 1'b1;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                ISSUE: begin
                    if (settle_cnt == '0) begin
                        rsp_data   <= alu_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        alu_en     <= 1'b0;
                        alu_opcode <= OP_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + CNT_W'(1);
                        alu_en     <= 1'b0;
                        alu_opcode <= OP_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: table vectors, hand-written reset/backpressure/wrap sequences, random commands vs a reference model.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [4:0]       alu_opcode;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [CNT_W-1:0] done_count;

    int checks   = 0;
    int failures = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_en     (alu_en),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .done_count (done_count)
    );

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a * b;
            5'd3:  return (b == 0) ? 32'd0 : a / b;
            5'd4:  return (b == 0) ? 32'd0 : a % b;
            5'd5:  return b - a;
            5'd6:  return (a == 0) ? 32'd0 : b / a;
            5'd7:  return (a == 0) ? 32'd0 : b % a;
            5'd8:  return a & b;
            5'd9:  return a | b;
            5'd10: return a ^ b;
            5'd11: return ~a;
            5'd12: return ~b;
            5'd13: return a << b[4:0];
            5'd14: return a >> b[4:0];
            5'd15: return $unsigned($signed(a) >>> b[4:0]);
            5'd16: return {31'd0, a == b};
            5'd17: return {31'd0, $signed(a) < $signed(b)};
            5'd18: return {31'd0, a < b};
            5'd19: return a;
            5'd20: return b;
            5'd21: return -a;
            5'd22: return a + 1;
            5'd23: return b + 1;
            default: return 32'd0;
        endcase
    endfunction

    // ALU stand-in: output is corrupted until the pins have been held stable for a full cycle with en high.
    logic [31:0] p_in1 = '0, p_in2 = '0;
    logic [4:0]  p_op = '0;
    logic        p_en = 1'b0;
    always @(posedge clk) begin
        p_in1 <= alu_in1;
        p_in2 <= alu_in2;
        p_op  <= alu_opcode;
        p_en  <= alu_en;
    end
    wire settled = alu_en && p_en && alu_in1 == p_in1 && alu_in2 == p_in2 && alu_opcode == p_op;
    assign alu_result = settled ? alu_f(alu_opcode, alu_in1, alu_in2)
                                : (alu_f(alu_opcode, alu_in1, alu_in2) ^ 32'hA5A5_5A5A);

    function automatic void ref_rsp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] data, output logic err);
        err  = (op > 5'd23) || ((op == 5'd3 || op == 5'd4) && b == 0) || ((op == 5'd6 || op == 5'd7) && a == 0);
        data = err ? 32'd0 : alu_f(op, a, b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge.
    task automatic run_cmd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                           input logic [31:0] exp_data, input logic exp_err, input string tag);
        int k;
        int en_cycles;
        bit got, pins_ok, ready_ok, stable_ok;
        logic [31:0] in1_before, in2_before;
        in1_before = alu_in1;
        in2_before = alu_in2;
        rsp_ready  = 1'b0;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".cmd_ready"}, cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_opcode = 5'($urandom);
        cmd_a      = $urandom;
        cmd_b      = $urandom;
        en_cycles = 0;
        got = 0;
        pins_ok = 1;
        ready_ok = 1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cmd_ready) ready_ok = 0;
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (alu_en) begin
                en_cycles++;
                if (alu_in1 !== a || alu_in2 !== b || alu_opcode !== op) pins_ok = 0;
            end
        end
        chk({tag, ".latency"}, got ? k : 0, exp_err ? 1 : SETTLE + 1);
        chk({tag, ".en_cycles"}, en_cycles, exp_err ? 0 : SETTLE);
        chk({tag, ".pins"}, pins_ok, 1);
        if (!got) return;
        chk({tag, ".data"}, rsp_data, exp_data);
        chk({tag, ".err"}, rsp_err, exp_err);
        if (exp_err) chk({tag, ".pins_untouched"}, {alu_in1, alu_in2}, {in1_before, in2_before});
        stable_ok = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== exp_data || rsp_err !== exp_err || cmd_ready
                || done_count !== CNT_W'(exp_done)) stable_ok = 0;
        end
        chk({tag, ".hold_stable"}, {stable_ok, ready_ok}, 2'b11);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_done = (exp_done + 1) % CNT_MOD;
        @(negedge clk);
        chk({tag, ".done_count"}, done_count, exp_done);
        chk({tag, ".after_hs"}, {rsp_valid, alu_en, alu_opcode, cmd_ready}, {1'b0, 1'b0, 5'd31, 1'b1});
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vec[16];

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b, ed;
        logic        ee;
        bit          saw_rsp;

        vec[0]  = '{5'd0,  32'd5,          32'd7,          0, 32'd12,         1'b0};
        vec[1]  = '{5'd3,  32'd10,         32'd0,          0, 32'd0,          1'b1};
        vec[2]  = '{5'd25, 32'd1,          32'd1,          0, 32'd0,          1'b1};
        vec[3]  = '{5'd5,  32'd3,          32'd10,         0, 32'd7,          1'b0};
        vec[4]  = '{5'd2,  32'd6,          32'd7,          5, 32'd42,         1'b0};
        vec[5]  = '{5'd6,  32'd0,          32'd4,          0, 32'd0,          1'b1};
        vec[6]  = '{5'd7,  32'd0,          32'd9,          2, 32'd0,          1'b1};
        vec[7]  = '{5'd4,  32'd8,          32'd0,          0, 32'd0,          1'b1};
        vec[8]  = '{5'd4,  32'd17,         32'd5,          0, 32'd2,          1'b0};
        vec[9]  = '{5'd7,  32'd3,          32'd17,         1, 32'd2,          1'b0};
        vec[10] = '{5'd23, 32'd0,          32'hFFFF_FFFF,  0, 32'd0,          1'b0};
        vec[11] = '{5'd1,  32'd3,          32'd5,          0, 32'hFFFF_FFFE,  1'b0};
        vec[12] = '{5'd31, 32'd0,          32'd0,          0, 32'd0,          1'b1};
        vec[13] = '{5'd24, 32'd4,          32'd4,          0, 32'd0,          1'b1};
        vec[14] = '{5'd15, 32'h8000_0000,  32'd4,          0, 32'hF800_0000,  1'b0};
        vec[15] = '{5'd17, 32'hFFFF_FFFF,  32'd1,          0, 32'd1,          1'b0};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_opcode = '0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset.ctrl", {cmd_ready, alu_en, alu_opcode, rsp_valid, rsp_err}, {1'b1, 1'b0, 5'd31, 1'b0, 1'b0});
        chk("reset.data", {alu_in1, alu_in2}, 64'd0);
        chk("reset.rsp_data", rsp_data, 0);
        chk("reset.done_count", done_count, 0);

        for (int i = 0; i < 16; i++)
            run_cmd(vec[i].op, vec[i].a, vec[i].b, vec[i].hold, vec[i].exp_data, vec[i].exp_err,
                    $sformatf("vec%0d", i));

        // Reset during the second ISSUE cycle drops the in-flight response.
        cmd_opcode = 5'd0;
        cmd_a = 32'd5;
        cmd_b = 32'd7;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_done = 0;
        @(negedge clk);
        chk("midrst.ctrl", {cmd_ready, alu_en, alu_opcode, rsp_valid}, {1'b1, 1'b0, 5'd31, 1'b0});
        chk("midrst.done_count", done_count, 0);
        chk("midrst.pins", {alu_in1, alu_in2}, 64'd0);
        saw_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) saw_rsp = 1;
            @(negedge clk);
        end
        chk("midrst.no_rsp", saw_rsp, 0);
        run_cmd(5'd22, 32'd9, 32'd0, 0, 32'd10, 1'b0, "post_rst");

        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                rsp_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            a  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            ref_rsp(op, a, b, ed, ee);
            run_cmd(op, a, b, $urandom_range(0, 3), ed, ee, $sformatf("rnd%0d", n));
        end

        while (exp_done != CNT_MOD - 1)
            run_cmd(5'd26, 32'd1, 32'd1, 0, 32'd0, 1'b1, "fill");
        chk("wrap.full", done_count, CNT_MOD - 1);
        run_cmd(5'd0, 32'd1, 32'd2, 0, 32'd3, 1'b0, "wrap");
        chk("wrap.zero", done_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
